// File: rtl/ram_ctrl_sync_if.sv
// CPU-side memory handshake bundle (Enable/ReadWrite/Size/Sign -> MOC) for ram_ctrl_sync.
interface ram_ctrl_sync_if;
  logic        Enable;
  logic        ReadWrite;
  logic [1:0]  Size;
  logic        Sign;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        AlignErr;
  logic        Busy;

  modport master (
    output Enable, ReadWrite, Size, Sign, Address, DataIn,
    input  DataOut, MOC, AlignErr, Busy
  );

  modport slave (
    input  Enable, ReadWrite, Size, Sign, Address, DataIn,
    output DataOut, MOC, AlignErr, Busy
  );
endinterface

// File: rtl/ram_ctrl_sync.sv
// Clocked byte-addressable RAM with wait states, four-phase MOC handshake and alignment faults.
// Big-endian by default; define RAM_LITTLE_ENDIAN_EN for little-endian byte order.
module ram_ctrl_sync #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic           Clk,
  input logic           Reset,
  ram_ctrl_sync_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    accept;
  logic [3:0]              cnt_q;
  logic                    err_q;
  logic [31:0]             dout_q;

  logic                    rw_q;
  logic [1:0]              size_q;
  logic                    sign_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             din_q;

  logic [7:0]              mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   lane_addr [4];
  logic [7:0]              rb [4];
  logic [7:0]              wdat [4];
  logic [3:0]              wen;
  logic [31:0]             raw;
  logic                    misalign;
  logic                    unused_addr;

  assign unused_addr = ^bus.Address[31:ADDR_WIDTH];

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] v);
    case (sz)
      2'd0:    extend = sg ? {{24{v[7]}},  v[7:0]}  : {24'd0, v[7:0]};
      2'd1:    extend = sg ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Control FSM: next state and accept strobe
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.Enable) begin
        accept  = 1'b1;
        state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT:    if (cnt_q == WS_LAST) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    if (!bus.Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= cnt_q + 4'd1;
      if (state_q == ACCESS) begin
        err_q <= misalign;
        if (rw_q && !misalign)
          dout_q <= extend(size_q, sign_q, raw);
      end
    end
  end

  // Request capture: inputs are ignored once the request is accepted
  always_ff @(posedge Clk) begin
    if (accept) begin
      rw_q   <= bus.ReadWrite;
      size_q <= bus.Size;
      sign_q <= bus.Sign;
      addr_q <= bus.Address[ADDR_WIDTH-1:0];
      din_q  <= bus.DataIn;
    end
  end

  always_comb begin
    misalign = (size_q == 2'd3) ||
               (size_q == 2'd1 && addr_q[0]) ||
               (size_q == 2'd2 && addr_q[1:0] != 2'b00);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr_q + ADDR_WIDTH'(i);
      rb[i]        = mem[lane_addr[i]];
      wdat[i]      = din_q[8*i +: 8];
    end
    case (size_q)
      2'd0:    wen = 4'b0001;
      2'd1:    wen = 4'b0011;
      default: wen = 4'b1111;
    endcase
`ifdef RAM_LITTLE_ENDIAN_EN
    case (size_q)
      2'd0:    raw = {24'd0, rb[0]};
      2'd1:    raw = {16'd0, rb[1], rb[0]};
      default: raw = {rb[3], rb[2], rb[1], rb[0]};
    endcase
`else
    case (size_q)
      2'd0: raw = {24'd0, rb[0]};
      2'd1: begin
        raw     = {16'd0, rb[0], rb[1]};
        wdat[0] = din_q[15:8];
        wdat[1] = din_q[7:0];
      end
      default: begin
        raw     = {rb[0], rb[1], rb[2], rb[3]};
        wdat[0] = din_q[31:24];
        wdat[1] = din_q[23:16];
        wdat[2] = din_q[15:8];
        wdat[3] = din_q[7:0];
      end
    endcase
`endif
  end

  // Store commits on the edge leaving ACCESS; a reset on that edge drops it whole
  always_ff @(posedge Clk) begin
    if (!Reset && state_q == ACCESS && !rw_q && !misalign) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) mem[lane_addr[i]] <= wdat[i];
    end
  end

  assign bus.DataOut  = dout_q;
  assign bus.MOC      = (state_q == DONE);
  assign bus.AlignErr = (state_q == DONE) && err_q;
  assign bus.Busy     = (state_q == WAIT) || (state_q == ACCESS);

endmodule

// File: tb/tb_ram_ctrl_sync.sv
// Directed bench for ram_ctrl_sync: one WAIT_STATES=2 instance and one WAIT_STATES=0 instance.
module tb_ram_ctrl_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ram_ctrl_sync_if b0 ();
  ram_ctrl_sync_if b1 ();

  ram_ctrl_sync #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut0 (.Clk(clk), .Reset(rst), .bus(b0.slave));
  ram_ctrl_sync #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut1 (.Clk(clk), .Reset(rst), .bus(b1.slave));

  // Full request on dut0 with Enable held until MOC; returns edges-to-MOC (-1 on timeout)
  task automatic xact(input logic rw, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic err, output logic [31:0] dout);
    @(negedge clk);
    b0.ReadWrite = rw; b0.Size = sz; b0.Sign = sg; b0.Address = a; b0.DataIn = d;
    b0.Enable = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b0.MOC === 1'b1) begin lat = n; break; end
    end
    err  = b0.AlignErr;
    dout = b0.DataOut;
    @(negedge clk);
    b0.Enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (b0.MOC !== 1'b0) begin bad++; $display("FAIL reset_moc got=%b want=0", b0.MOC); end
    total++; if (b0.AlignErr !== 1'b0) begin bad++; $display("FAIL reset_alignerr got=%b want=0", b0.AlignErr); end
    total++; if (b0.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b0.Busy); end
    total++; if (b0.DataOut !== 32'h0) begin bad++; $display("FAIL reset_dataout got=%h want=0", b0.DataOut); end
    total++; if (b1.MOC !== 1'b0) begin bad++; $display("FAIL reset_moc_ws0 got=%b want=0", b1.MOC); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_bytes();
    int lat; logic err; logic [31:0] dout;
    logic [7:0] exp_b [4];
`ifdef RAM_LITTLE_ENDIAN_EN
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
`else
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
`endif
    xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h12345678, lat, err, dout);
    total++; if (lat !== 3) begin bad++; $display("FAIL store_word_latency got=%0d want=3", lat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL store_word_err got=%b want=0", err); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL store_keeps_dataout got=%h want=0", dout); end
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 2'd0, 1'b0, 32'h04 + i, 32'h0, lat, err, dout);
      total++; if (lat !== 3) begin bad++; $display("FAIL load_byte%0d_latency got=%0d want=3", i, lat); end
      total++; if (dout !== {24'h0, exp_b[i]}) begin bad++; $display("FAIL load_byte%0d got=%h want=%h", i, dout, {24'h0, exp_b[i]}); end
    end
    xact(1'b0, 2'd2, 1'b0, 32'h08, 32'h9ABCDEF0, lat, err, dout);
  endtask

  task automatic test_half_sign();
    int lat; logic err; logic [31:0] dout; logic [31:0] exp_byte;
`ifdef RAM_LITTLE_ENDIAN_EN
    exp_byte = 32'hFFFFFF80;
`else
    exp_byte = 32'hFFFFFFFE;
`endif
    xact(1'b0, 2'd1, 1'b0, 32'h10, 32'h000080FE, lat, err, dout);
    xact(1'b1, 2'd1, 1'b1, 32'h10, 32'h0, lat, err, dout);
    total++; if (dout !== 32'hFFFF80FE) begin bad++; $display("FAIL half_sext got=%h want=ffff80fe", dout); end
    xact(1'b1, 2'd1, 1'b0, 32'h10, 32'h0, lat, err, dout);
    total++; if (dout !== 32'h000080FE) begin bad++; $display("FAIL half_zext got=%h want=000080fe", dout); end
    xact(1'b1, 2'd0, 1'b1, 32'h11, 32'h0, lat, err, dout);
    total++; if (dout !== exp_byte) begin bad++; $display("FAIL byte_sext got=%h want=%h", dout, exp_byte); end
  endtask

  task automatic test_byte_store();
    int lat; logic err; logic [31:0] dout; logic [31:0] exp_w;
`ifdef RAM_LITTLE_ENDIAN_EN
    exp_w = 32'h0102037F;
`else
    exp_w = 32'h7F020304;
`endif
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h01020304, lat, err, dout);
    xact(1'b0, 2'd0, 1'b0, 32'h20, 32'hAABBCC7F, lat, err, dout);
    xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, lat, err, dout);
    total++; if (dout !== exp_w) begin bad++; $display("FAIL byte_store_word got=%h want=%h", dout, exp_w); end
  endtask

  task automatic test_align();
    int lat; logic err; logic [31:0] dout;
    xact(1'b0, 2'd2, 1'b0, 32'h06, 32'hCAFEBABE, lat, err, dout);
    total++; if (lat !== 3) begin bad++; $display("FAIL misaligned_word_latency got=%0d want=3", lat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL misaligned_word_err got=%b want=1", err); end
    total++; if (b0.AlignErr !== 1'b0) begin bad++; $display("FAIL alignerr_clears got=%b want=0", b0.AlignErr); end
    xact(1'b0, 2'd1, 1'b0, 32'h05, 32'h0000FFFF, lat, err, dout);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL misaligned_half_err got=%b want=1", err); end
    xact(1'b1, 2'd2, 1'b0, 32'h04, 32'h0, lat, err, dout);
    total++; if (dout !== 32'h12345678 || err !== 1'b0) begin bad++; $display("FAIL untouched_04 got=%h want=12345678", dout); end
    xact(1'b1, 2'd2, 1'b0, 32'h08, 32'h0, lat, err, dout);
    total++; if (dout !== 32'h9ABCDEF0) begin bad++; $display("FAIL untouched_08 got=%h want=9abcdef0", dout); end
    xact(1'b1, 2'd3, 1'b0, 32'h08, 32'h0, lat, err, dout);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL size3_err got=%b want=1", err); end
    total++; if (dout !== 32'h9ABCDEF0) begin bad++; $display("FAIL size3_dataout got=%h want=9abcdef0", dout); end
    xact(1'b1, 2'd1, 1'b1, 32'h11, 32'h0, lat, err, dout);
    total++; if (err !== 1'b1 || dout !== 32'h9ABCDEF0) begin bad++; $display("FAIL misaligned_half_load got=%b/%h want=1/9abcdef0", err, dout); end
  endtask

  task automatic test_wrap();
    int lat; logic err; logic [31:0] dout;
    xact(1'b0, 2'd2, 1'b0, 32'hFC, 32'hA1B2C3D4, lat, err, dout);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL last_word_err got=%b want=0", err); end
    xact(1'b1, 2'd2, 1'b0, 32'h1FC, 32'h0, lat, err, dout);
    total++; if (dout !== 32'hA1B2C3D4) begin bad++; $display("FAIL wrap_load got=%h want=a1b2c3d4", dout); end
  endtask

  task automatic test_early_drop();
    int highs = 0;
    @(negedge clk);
    b0.ReadWrite = 1'b1; b0.Size = 2'd2; b0.Sign = 1'b0; b0.Address = 32'h04; b0.Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.Enable = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (b0.MOC === 1'b1) highs++;
    end
    total++; if (highs !== 1) begin bad++; $display("FAIL early_drop_moc_cycles got=%0d want=1", highs); end
    total++; if (b0.DataOut !== 32'h12345678) begin bad++; $display("FAIL early_drop_data got=%h want=12345678", b0.DataOut); end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [31:0] dout; int highs = 0;
    xact(1'b0, 2'd2, 1'b0, 32'h30, 32'h11223344, lat, err, dout);
    @(negedge clk);
    b0.ReadWrite = 1'b0; b0.Size = 2'd2; b0.Address = 32'h30; b0.DataIn = 32'hDEADBEEF; b0.Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (b0.Busy !== 1'b0 || b0.DataOut !== 32'h0) begin bad++; $display("FAIL mid_reset_state busy=%b data=%h want=0/0", b0.Busy, b0.DataOut); end
    @(negedge clk);
    rst = 1'b0; b0.Enable = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (b0.MOC === 1'b1) highs++;
    end
    total++; if (highs !== 0) begin bad++; $display("FAIL mid_reset_moc got=%0d want=0", highs); end
    xact(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, lat, err, dout);
    total++; if (lat !== 3) begin bad++; $display("FAIL after_reset_latency got=%0d want=3", lat); end
    total++; if (dout !== 32'h11223344) begin bad++; $display("FAIL mid_reset_mem got=%h want=11223344", dout); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    b1.ReadWrite = 1'b0; b1.Size = 2'd2; b1.Sign = 1'b0; b1.Address = 32'h40; b1.DataIn = 32'h55667788;
    b1.Enable = 1'b1;
    @(posedge clk); #1;
    total++; if (b1.Busy !== 1'b1 || b1.MOC !== 1'b0) begin bad++; $display("FAIL ws0_accept busy=%b moc=%b want=1/0", b1.Busy, b1.MOC); end
    @(posedge clk); #1;
    total++; if (b1.MOC !== 1'b1 || b1.AlignErr !== 1'b0) begin bad++; $display("FAIL ws0_moc moc=%b err=%b want=1/0", b1.MOC, b1.AlignErr); end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      total++; if (b1.MOC !== 1'b1) begin bad++; $display("FAIL ws0_moc_hold%0d got=%b want=1", n, b1.MOC); end
    end
    @(negedge clk);
    b1.Enable = 1'b0;
    @(posedge clk); #1;
    total++; if (b1.MOC !== 1'b0 || b1.Busy !== 1'b0) begin bad++; $display("FAIL ws0_release moc=%b busy=%b want=0/0", b1.MOC, b1.Busy); end
    @(negedge clk);
    b1.ReadWrite = 1'b1; b1.Enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.Enable = 1'b0;
    @(posedge clk); #1;
    total++; if (b1.MOC !== 1'b1 || b1.DataOut !== 32'h55667788) begin bad++; $display("FAIL ws0_load moc=%b data=%h want=1/55667788", b1.MOC, b1.DataOut); end
    @(posedge clk); #1;
    total++; if (b1.MOC !== 1'b0) begin bad++; $display("FAIL ws0_single_moc got=%b want=0", b1.MOC); end
  endtask

  initial begin
    b0.Enable = 1'b0; b0.ReadWrite = 1'b0; b0.Size = 2'd0; b0.Sign = 1'b0;
    b0.Address = 32'h0; b0.DataIn = 32'h0;
    b1.Enable = 1'b0; b1.ReadWrite = 1'b0; b1.Size = 2'd0; b1.Sign = 1'b0;
    b1.Address = 32'h0; b1.DataIn = 32'h0;
    test_reset();
    test_word_bytes();
    test_half_sign();
    test_byte_store();
    test_align();
    test_wrap();
    test_early_drop();
    test_reset_mid();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
